pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter LOAD_LAT, default 1, meaning load-use bubble count; legal range 1..3.
REQ-002 The block SHALL have parameter MAX_WAIT, default 15, meaning the maximum number of data-memory wait cycles before timeout; legal range 1..255.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning stall_count width.
REQ-004 The block SHALL have port CLK  in  1  clock; all state updates on the rising edge.
REQ-005 The block SHALL have port RST  in  1  reset, synchronous, active-low.
REQ-006 The block SHALL have ports rs1_id, rs2_id  in  5 each  source registers of the instruction in IF/ID.
REQ-007 The block SHALL have port uses_rs2_id  in  1  IF/ID instruction reads rs2.
REQ-008 The block SHALL have ports rd_ex  in  5  and memread_ex  in  1  destination register and load flag held in ID/EX.
REQ-009 The block SHALL have ports branch_mem, zero_mem  in  1 each  EX/MEM branch flag and zero flag; taken = branch_mem & zero_mem.
REQ-010 The block SHALL have ports mem_req  in  1 (EX/MEM load/store valid) and mem_ready  in  1 (data memory done).
REQ-011 The block SHALL have ports pc_write, ifid_write, idex_write  out  1 each  register enables.
REQ-012 The block SHALL have ports ifid_flush, idex_flush, exmem_flush  out  1 each  bubble-insert controls.
REQ-013 The block SHALL have ports exmem_hold  out  1, pc_sel_branch  out  1, mem_timeout  out  1 (sticky), stall_count  out  CNT_W, and state  out  2.

Function
REQ-014 The block SHALL encode state as RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3; state is registered, and control outputs are combinational from state and the current-cycle inputs.
REQ-015 The block SHALL use these defaults unless overridden by REQ-016 to REQ-022: pc_write=ifid_write=idex_write=1, all flushes=0, exmem_hold=0, pc_sel_branch=0.
REQ-016 The block SHALL define load_use = memread_ex & (rd_ex!=0) & ((rd_ex==rs1_id) | (uses_rs2_id & rd_ex==rs2_id)).
REQ-017 The block SHALL evaluate conditions in RUN in this priority: mem_req&!mem_ready, then taken, then load_use, then none; only the highest-priority condition acts.
REQ-018 On mem wait, the block SHALL drive pc_write=ifid_write=idex_write=0 and exmem_hold=1 in the same cycle, clear the wait counter to 1, and go to MEM_WAIT.
REQ-019 In MEM_WAIT with mem_ready=0, the block SHALL keep the REQ-018 outputs and increment the wait counter.
  - On reaching MAX_WAIT: set mem_timeout=1, assert exmem_flush=1 with exmem_hold=0 that cycle, and go to RUN.
REQ-020 In MEM_WAIT with mem_ready=1, the block SHALL apply default outputs that cycle and go to RUN; the wait counter is cleared.
REQ-021 On taken in RUN or LOAD_STALL, the block SHALL drive pc_sel_branch=1, pc_write=1, and ifid_flush=idex_flush=exmem_flush=1 in the same cycle, then go to FLUSH.
  - A LOAD_STALL in progress is abandoned.
REQ-022 On load_use in RUN, the block SHALL drive pc_write=ifid_write=0 and idex_flush=1.
  - If LOAD_LAT==1: stay in RUN.
  - Otherwise: load the bubble counter with LOAD_LAT-1 and go to LOAD_STALL.
REQ-023 In LOAD_STALL, the block SHALL drive the REQ-022 outputs each cycle and decrement the bubble counter, going to RUN in the cycle the counter reads 1; total stalled cycles = LOAD_LAT.
REQ-024 In LOAD_STALL, mem_req&!mem_ready SHALL take precedence: REQ-018 applies and the bubble count is discarded.
REQ-025 FLUSH SHALL last exactly one cycle with default outputs and load_use ignored; the next state is RUN.
  - A mem wait in FLUSH is still honored per REQ-018.
REQ-026 stall_count SHALL increment by 1 on every non-reset cycle with pc_write=0 and saturate at all-ones.
REQ-027 mem_timeout SHALL remain 1 until reset.

Reset
REQ-028 While RST=0 at a rising edge, the block SHALL set the next state to RUN, clear the wait counter, bubble counter and stall_count, and set mem_timeout=0.
REQ-029 During any cycle with RST=0, the block SHALL drive pc_write=ifid_write=idex_write=0, ifid_flush=idex_flush=exmem_flush=1, exmem_hold=0 and pc_sel_branch=0, regardless of state.
REQ-030 Reset asserted mid-MEM_WAIT or mid-LOAD_STALL SHALL abandon the operation with no timeout flagged.

Verification
REQ-031 Load-use check: memread_ex=1, rd_ex=5, rs1_id=5, LOAD_LAT=1 -> one cycle of pc_write=0 and idex_flush=1, state stays 0, stall_count=1.
REQ-032 Zero-register check: the same as REQ-031 with rd_ex=0 -> no stall.
  - With rs2_id=5 and uses_rs2_id=0 -> no stall.
REQ-033 Extended bubble check: LOAD_LAT=3 with a load-use hazard -> exactly 3 stalled cycles, state sequence 0,1,1,0.
REQ-034 Branch check: taken in RUN coincident with load_use -> all three flushes and pc_sel_branch=1, no stall, state 2 then 0.
REQ-035 Memory-wait check: mem_req=1 and mem_ready low for 4 cycles -> holds for 4 cycles, release on the ready cycle, mem_timeout=0, stall_count=4.
  - With MAX_WAIT=15 and ready never asserted -> timeout on the 15th wait cycle, exmem_flush=1, mem_timeout sticks.
REQ-036 Reset check: RST=0 asserted in MEM_WAIT -> state 0, counters 0, reset output pattern per REQ-029.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : 5-stage pipeline hazard unit (load-use, branch flush, mem wait)
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             uses_rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             memread_ex,
    input  logic             branch_mem,
    input  logic             zero_mem,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             exmem_hold,
    output logic             pc_sel_branch,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       state
);

    localparam logic [1:0] c_st_run        = 2'd0;
    localparam logic [1:0] c_st_load_stall = 2'd1;
    localparam logic [1:0] c_st_flush      = 2'd2;
    localparam logic [1:0] c_st_mem_wait   = 2'd3;
    localparam logic [7:0] c_max_wait      = 8'(MAX_WAIT);
    localparam logic [1:0] c_bub_init      = 2'(LOAD_LAT - 1);

    logic [1:0]       r_state, w_state_nxt;
    logic [7:0]       r_wait_cnt, w_wait_nxt, w_wait_cur;
    logic [1:0]       r_bub_cnt, w_bub_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_timeout, w_timeout_set;
    logic             w_taken, w_mem_wait, w_load_use, w_wait_hit;

    assign w_taken    = branch_mem & zero_mem;
    assign w_mem_wait = mem_req & ~mem_ready;
    assign w_load_use = memread_ex & (rd_ex != 5'd0) &
                        ((rd_ex == rs1_id) | (uses_rs2_id & (rd_ex == rs2_id)));
    // Once waiting, only mem_ready releases the hold; w_wait_cur is this cycle's wait number.
    assign w_wait_hit = (r_state == c_st_mem_wait) ? ~mem_ready : w_mem_wait;
    assign w_wait_cur = (r_state == c_st_mem_wait) ? r_wait_cnt + 8'd1 : 8'd1;

    assign state       = r_state;
    assign stall_count = r_stall_cnt;
    assign mem_timeout = r_timeout;

    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        idex_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        exmem_hold    = 1'b0;
        pc_sel_branch = 1'b0;
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_bub_nxt     = r_bub_cnt;
        w_timeout_set = 1'b0;
        if (!RST) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (w_wait_hit) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            w_bub_nxt  = 2'd0;
            if (w_wait_cur == c_max_wait) begin
                exmem_flush   = 1'b1;
                w_timeout_set = 1'b1;
                w_wait_nxt    = 8'd0;
                w_state_nxt   = c_st_run;
            end else begin
                exmem_hold  = 1'b1;
                w_wait_nxt  = w_wait_cur;
                w_state_nxt = c_st_mem_wait;
            end
        end else begin
            case (r_state)
                c_st_mem_wait: begin
                    w_wait_nxt  = 8'd0;
                    w_state_nxt = c_st_run;
                end
                c_st_flush: begin
                    w_state_nxt = c_st_run;
                end
                default: begin
                    if (w_taken) begin
                        pc_sel_branch = 1'b1;
                        ifid_flush    = 1'b1;
                        idex_flush    = 1'b1;
                        exmem_flush   = 1'b1;
                        w_bub_nxt     = 2'd0;
                        w_state_nxt   = c_st_flush;
                    end else if (r_state == c_st_load_stall) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        w_bub_nxt  = r_bub_cnt - 2'd1;
                        if (r_bub_cnt <= 2'd1) begin
                            w_bub_nxt   = 2'd0;
                            w_state_nxt = c_st_run;
                        end
                    end else if (w_load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_bub_nxt   = c_bub_init;
                            w_state_nxt = c_st_load_stall;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= c_st_run;
            r_wait_cnt  <= 8'd0;
            r_bub_cnt   <= 2'd0;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_bub_cnt  <= w_bub_nxt;
            if (!pc_write && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_timeout_set)
                r_timeout <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : directed scoreboard bench for pipe_hazard_ctrl (LOAD_LAT 1 and 3)
// Revision : 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam logic [7:0] C_DEF = 8'b1110_0000;
    localparam logic [7:0] C_RST = 8'b0001_1100;
    localparam logic [7:0] C_LU  = 8'b0010_1000;
    localparam logic [7:0] C_BR  = 8'b1111_1101;
    localparam logic [7:0] C_MW  = 8'b0000_0010;
    localparam logic [7:0] C_TO  = 8'b0000_0100;

    logic CLK = 1'b0;
    logic RST;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic uses_rs2_id, memread_ex, branch_mem, zero_mem, mem_req, mem_ready;

    logic pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, exmem_hold, pc_sel_branch, mem_timeout;
    logic [15:0] stall_count;
    logic [1:0]  state;
    logic pc_write3, ifid_write3, idex_write3, ifid_flush3, idex_flush3, exmem_flush3, exmem_hold3, pc_sel_branch3, mem_timeout3;
    logic [15:0] stall_count3;
    logic [1:0]  state3;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.LOAD_LAT(1), .MAX_WAIT(15), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs2_id(uses_rs2_id),
        .rd_ex(rd_ex), .memread_ex(memread_ex), .branch_mem(branch_mem), .zero_mem(zero_mem),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_write(idex_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .exmem_hold(exmem_hold), .pc_sel_branch(pc_sel_branch),
        .mem_timeout(mem_timeout), .stall_count(stall_count), .state(state)
    );

    pipe_hazard_ctrl #(.LOAD_LAT(3), .MAX_WAIT(15), .CNT_W(16)) dut3 (
        .CLK(CLK), .RST(RST), .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs2_id(uses_rs2_id),
        .rd_ex(rd_ex), .memread_ex(memread_ex), .branch_mem(branch_mem), .zero_mem(zero_mem),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write3), .ifid_write(ifid_write3),
        .idex_write(idex_write3), .ifid_flush(ifid_flush3), .idex_flush(idex_flush3),
        .exmem_flush(exmem_flush3), .exmem_hold(exmem_hold3), .pc_sel_branch(pc_sel_branch3),
        .mem_timeout(mem_timeout3), .stall_count(stall_count3), .state(state3)
    );

    typedef struct {
        int          which;
        string       tag;
        logic [1:0]  st;
        logic [7:0]  ctl;
        logic [15:0] sc;
        logic        to;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_sc = 16'd0;
    logic        exp_to = 1'b0;

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                         input logic [4:0] rd, input logic mr, input logic br, input logic z,
                         input logic req, input logic rdy);
        rs1_id = r1; rs2_id = r2; uses_rs2_id = u2; rd_ex = rd; memread_ex = mr;
        branch_mem = br; zero_mem = z; mem_req = req; mem_ready = rdy;
    endtask

    // Queue the expectation for this cycle, roll the counter model forward, then compare at negedge.
    task automatic step(input int which, input string tag, input logic [1:0] est, input logic [7:0] ectl);
        exp_t e;
        exp_t o;
        logic [7:0]  obs_ctl;
        logic [1:0]  obs_st;
        e.which = which; e.tag = tag; e.st = est; e.ctl = ectl; e.sc = exp_sc; e.to = exp_to;
        sb.push_back(e);
        if (which == 0) begin
            if (!RST) begin
                exp_sc = 16'd0;
                exp_to = 1'b0;
            end else begin
                if (!ectl[7] && exp_sc != 16'hffff) exp_sc = exp_sc + 16'd1;
                if (ectl == C_TO) exp_to = 1'b1;
            end
        end
        @(negedge CLK);
        o = sb.pop_front();
        if (o.which == 0) begin
            obs_ctl = {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, exmem_hold, pc_sel_branch};
            obs_st  = state;
        end else begin
            obs_ctl = {pc_write3, ifid_write3, idex_write3, ifid_flush3, idex_flush3, exmem_flush3, exmem_hold3, pc_sel_branch3};
            obs_st  = state3;
        end
        checks++;
        assert (obs_ctl === o.ctl) else begin
            errors++;
            $error("FAIL %s ctl observed=%b expected=%b", o.tag, obs_ctl, o.ctl);
        end
        checks++;
        assert (obs_st === o.st) else begin
            errors++;
            $error("FAIL %s state observed=%0d expected=%0d", o.tag, obs_st, o.st);
        end
        if (o.which == 0) begin
            checks++;
            assert (stall_count === o.sc) else begin
                errors++;
                $error("FAIL %s stall_count observed=%0d expected=%0d", o.tag, stall_count, o.sc);
            end
            checks++;
            assert (mem_timeout === o.to) else begin
                errors++;
                $error("FAIL %s mem_timeout observed=%b expected=%b", o.tag, mem_timeout, o.to);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        step(0, "reset0", 2'd0, C_RST);
        step(0, "reset1", 2'd0, C_RST);
        RST = 1'b1;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, "idle", 2'd0, C_DEF);
        drive(5, 0, 0, 5, 1, 0, 0, 0, 0); step(0, "lu_rs1", 2'd0, C_LU);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, "lu_release", 2'd0, C_DEF);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0); step(0, "lu_x0", 2'd0, C_DEF);
        drive(3, 5, 0, 5, 1, 0, 0, 0, 0); step(0, "rs2_unused", 2'd0, C_DEF);
        drive(3, 5, 1, 5, 1, 0, 0, 0, 0); step(0, "lu_rs2", 2'd0, C_LU);
        drive(5, 0, 0, 5, 0, 0, 0, 0, 0); step(0, "no_load", 2'd0, C_DEF);
        drive(5, 0, 0, 5, 1, 1, 1, 0, 0); step(0, "br_over_lu", 2'd0, C_BR);
        drive(5, 0, 0, 5, 1, 0, 0, 0, 0); step(0, "flush_ignores_lu", 2'd2, C_DEF);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, "after_flush", 2'd0, C_DEF);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0); step(0, "br_not_taken", 2'd0, C_DEF);

        RST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, "reset_pre_mw", 2'd0, C_RST);
        RST = 1'b1;
        drive(5, 0, 0, 5, 1, 1, 1, 1, 0); step(0, "mw_prio", 2'd0, C_MW);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step(0, "mw2", 2'd3, C_MW);
        step(0, "mw3", 2'd3, C_MW);
        step(0, "mw4", 2'd3, C_MW);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1); step(0, "mw_ready", 2'd3, C_DEF);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, "mw_done", 2'd0, C_DEF);

        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 15; k++)
            step(0, $sformatf("to_w%0d", k), (k == 1) ? 2'd0 : 2'd3, (k == 15) ? C_TO : C_MW);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, "to_sticky", 2'd0, C_DEF);
        step(0, "to_sticky2", 2'd0, C_DEF);

        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step(0, "rmw1", 2'd0, C_MW);
        step(0, "rmw2", 2'd3, C_MW);
        RST = 1'b0; step(0, "rst_in_mw", 2'd3, C_RST);
        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, "post_rst", 2'd0, C_DEF);

        drive(5, 0, 0, 5, 1, 0, 0, 0, 0); step(1, "l3_c1", 2'd0, C_LU);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(1, "l3_c2", 2'd1, C_LU);
        step(1, "l3_c3", 2'd1, C_LU);
        step(1, "l3_done", 2'd0, C_DEF);
        drive(5, 0, 0, 5, 1, 0, 0, 0, 0); step(1, "l3_br_a", 2'd0, C_LU);
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0); step(1, "l3_br_b", 2'd1, C_BR);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(1, "l3_br_c", 2'd2, C_DEF);
        step(1, "l3_br_d", 2'd0, C_DEF);
        drive(5, 0, 0, 5, 1, 0, 0, 0, 0); step(1, "l3_mw_a", 2'd0, C_LU);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step(1, "l3_mw_b", 2'd1, C_MW);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1); step(1, "l3_mw_c", 2'd3, C_DEF);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(1, "l3_mw_d", 2'd0, C_DEF);

        // Six stalled cycles on the LOAD_LAT=3 instance since the mid-wait reset.
        checks++;
        assert (stall_count3 === 16'd6) else begin
            errors++;
            $error("FAIL l3_stall_count observed=%0d expected=6", stall_count3);
        end
        checks++;
        assert (mem_timeout3 === 1'b0) else begin
            errors++;
            $error("FAIL l3_timeout observed=%b expected=0", mem_timeout3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
